// File: rtl/muldiv_seq.sv
// muldiv_seq: multi-cycle RV32M multiply/divide sequencer (shift-add multiply, restoring divide)
// that borrows the shared add/sub ALU for its per-iteration add or subtract.
module muldiv_seq #(
    parameter int XLEN = 32,
    parameter int ITER = 32
) (
    input  logic            i_clk,
    input  logic            i_rst_n,
    input  logic            i_flush,
    input  logic            i_req_valid,
    output logic            o_req_ready,
    input  logic [2:0]      i_req_op,
    input  logic [XLEN-1:0] i_req_a,
    input  logic [XLEN-1:0] i_req_b,
    output logic            o_res_valid,
    input  logic            i_res_ready,
    output logic [XLEN-1:0] o_res_data,
    output logic            o_busy,
    output logic [2:0]      o_alu_opsel,
    output logic            o_alu_sub,
    output logic            o_alu_unsigned,
    output logic            o_alu_arith,
    output logic [XLEN-1:0] o_alu_op1,
    output logic [XLEN-1:0] o_alu_op2,
    input  logic [XLEN-1:0] i_alu_result,
    input  logic            i_alu_slt
);
    localparam int CW = $clog2(ITER);

    typedef enum logic [2:0] {IDLE, PREP, RUN, FIX, DONE} state_t;

    state_t          state, state_nxt;
    logic [2:0]      op;
    logic [XLEN-1:0] a, b, hi, lo;
    logic [CW-1:0]   cnt;
    logic            neg;

    logic              is_div, sa, sb, run, accept, div_zero, top, carry, take;
    logic [XLEN-1:0]   mag_a, mag_b, t, div_sel, div_fix;
    logic [2*XLEN-1:0] prod_fix;

    assign is_div   = op[2];
    assign sa       = op[2] ? ~op[0] : (op[1:0] != 2'b11);
    assign sb       = op[2] ? ~op[0] : (op[1:0] == 2'b01);
    assign mag_a    = (sa & a[XLEN-1]) ? -a : a;
    assign mag_b    = (sb & b[XLEN-1]) ? -b : b;
    assign run      = (state == RUN);
    assign accept   = (state == IDLE) & i_req_valid & ~i_flush;
    assign div_zero = i_req_op[2] & (i_req_b == '0);

    // Divide keeps the remainder in hi and the quotient/dividend in lo.
    assign t        = {hi[XLEN-2:0], lo[XLEN-1]};
    assign top      = hi[XLEN-1];
    assign take     = top | ~i_alu_slt;
    assign carry    = i_alu_result < hi;
    assign prod_fix = neg ? -{hi, lo} : {hi, lo};
    assign div_sel  = op[1] ? hi : lo;
    assign div_fix  = neg ? -div_sel : div_sel;

    assign o_req_ready    = (state == IDLE) & ~i_flush;
    assign o_busy         = (state != IDLE);
    assign o_res_valid    = (state == DONE);
    assign o_alu_opsel    = 3'b000;
    assign o_alu_arith    = 1'b0;
    assign o_alu_sub      = run & is_div;
    assign o_alu_unsigned = run & is_div;
    assign o_alu_op1      = run ? (is_div ? t : hi) : '0;
    assign o_alu_op2      = run ? (is_div ? b : a) : '0;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) state <= IDLE;
        else          state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    state_nxt = i_req_valid ? (div_zero ? DONE : PREP) : IDLE;
            PREP:    state_nxt = RUN;
            RUN:     state_nxt = (cnt == CW'(ITER - 1)) ? FIX : RUN;
            FIX:     state_nxt = DONE;
            DONE:    state_nxt = i_res_ready ? IDLE : DONE;
            default: state_nxt = IDLE;
        endcase
        if (i_flush) state_nxt = IDLE;
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            op         <= '0;
            a          <= '0;
            b          <= '0;
            hi         <= '0;
            lo         <= '0;
            cnt        <= '0;
            neg        <= 1'b0;
            o_res_data <= '0;
        end else begin
            case (state)
                IDLE: if (accept) begin
                    op <= i_req_op;
                    a  <= i_req_a;
                    b  <= i_req_b;
                    if (div_zero) o_res_data <= i_req_op[1] ? i_req_a : '1;
                end
                // a and b are replaced by their magnitudes for the rest of the operation.
                PREP: begin
                    a   <= mag_a;
                    b   <= mag_b;
                    neg <= (is_div & op[1]) ? (sa & a[XLEN-1])
                                            : ((sa & a[XLEN-1]) ^ (sb & b[XLEN-1]));
                    cnt <= '0;
                    hi  <= '0;
                    lo  <= is_div ? mag_a : mag_b;
                end
                RUN: begin
                    cnt <= cnt + 1'b1;
                    if (is_div) begin
                        hi <= take ? i_alu_result : t;
                        lo <= {lo[XLEN-2:0], take};
                    end else if (lo[0]) begin
                        {hi, lo} <= {carry, i_alu_result, lo[XLEN-1:1]};
                    end else begin
                        {hi, lo} <= {1'b0, hi, lo[XLEN-1:1]};
                    end
                end
                FIX: o_res_data <= is_div ? div_fix
                                 : (op[1:0] == 2'b00) ? prod_fix[XLEN-1:0] : prod_fix[2*XLEN-1:XLEN];
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_muldiv_seq.sv
// tb_muldiv_seq: directed and randomized checks of muldiv_seq against an arithmetic reference,
// with a behavioural add/sub ALU closing the loop.
module tb_muldiv_seq;
    logic        clk = 0, rst_n = 1, flush = 0, req_valid = 0, res_ready = 1;
    logic [2:0]  req_op = 0;
    logic [31:0] req_a = 0, req_b = 0;
    logic        req_ready, res_valid, busy, alu_sub, alu_unsigned, alu_arith, alu_slt;
    logic [31:0] res_data, alu_op1, alu_op2, alu_result;
    logic [2:0]  alu_opsel;
    int          n_checks = 0, n_fail = 0;

    muldiv_seq dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_flush(flush),
        .i_req_valid(req_valid), .o_req_ready(req_ready), .i_req_op(req_op),
        .i_req_a(req_a), .i_req_b(req_b),
        .o_res_valid(res_valid), .i_res_ready(res_ready), .o_res_data(res_data),
        .o_busy(busy), .o_alu_opsel(alu_opsel), .o_alu_sub(alu_sub),
        .o_alu_unsigned(alu_unsigned), .o_alu_arith(alu_arith),
        .o_alu_op1(alu_op1), .o_alu_op2(alu_op2),
        .i_alu_result(alu_result), .i_alu_slt(alu_slt)
    );

    always #5 clk = ~clk;

    assign alu_result = alu_sub ? alu_op1 - alu_op2 : alu_op1 + alu_op2;
    assign alu_slt    = alu_unsigned ? (alu_op1 < alu_op2) : ($signed(alu_op1) < $signed(alu_op2));

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, observed timeout required completion");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        logic [63:0] sxa, sxb, ua, ub, p;
        int          si, sj;
        sxa = {{32{a[31]}}, a};
        sxb = {{32{b[31]}}, b};
        ua  = {32'b0, a};
        ub  = {32'b0, b};
        si  = a;
        sj  = b;
        case (op)
            3'd0: begin p = sxa * sxb; return p[31:0];  end
            3'd1: begin p = sxa * sxb; return p[63:32]; end
            3'd2: begin p = sxa * ub;  return p[63:32]; end
            3'd3: begin p = ua * ub;   return p[63:32]; end
            3'd4: return (b == 0) ? 32'hFFFF_FFFF : (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) ? a : 32'(si / sj);
            3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
            3'd6: return (b == 0) ? a : (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) ? 32'h0 : 32'(si % sj);
            default: return (b == 0) ? a : a % b;
        endcase
    endfunction

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 5))
            0: return 32'h0;
            1: return 32'hFFFF_FFFF;
            2: return 32'h8000_0000;
            3: return 32'($urandom_range(0, 20));
            default: return $urandom;
        endcase
    endfunction

    // Issues one request, waits (bounded) for the result, then lets the handshake return to IDLE.
    // lat counts rising edges after the accepting edge until o_res_valid is seen.
    task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                          output logic [31:0] data, output int lat,
                          output logic sub_any, output logic uns_any, output logic fixed_bad);
        @(negedge clk);
        req_valid = 1; req_op = op; req_a = a; req_b = b;
        @(posedge clk); #1;
        req_valid = 0;
        lat = 0; sub_any = 0; uns_any = 0; fixed_bad = 0;
        while (!res_valid && lat < 100) begin
            sub_any   |= alu_sub;
            uns_any   |= alu_unsigned;
            fixed_bad |= (alu_opsel != 3'b000) | alu_arith;
            @(posedge clk); #1;
            lat++;
        end
        data = res_data;
        @(posedge clk); #1;
    endtask

    logic [31:0] d, d0;
    int          lat;
    logic        s_any, u_any, f_bad, seen;
    logic [31:0] dir_exp [8] = '{32'hFFFF_FFF1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0002,
                                 32'hFFFF_FFFF, 32'h5555_5553, 32'hFFFF_FFFE, 32'h0000_0002};

    initial begin
        #1 rst_n = 0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_valid", res_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_data", res_data, 0);
        check("rst_alu_ops", {alu_op1, alu_op2}, 0);
        check("rst_alu_ctl", {alu_opsel, alu_sub, alu_unsigned, alu_arith}, 0);
        @(negedge clk) rst_n = 1;
        @(posedge clk); #1;
        check("idle_ready", req_ready, 1);

        run_op(3'd0, 5, 6, d, lat, s_any, u_any, f_bad);
        check("mul_5x6", d, 32'h1E);
        check("mul_latency", lat, 34);
        check("mul_sub_low", s_any, 0);
        check("mul_fixed_ctl", f_bad, 0);
        check("idle_alu_zero", {alu_op1, alu_op2, alu_sub, alu_unsigned}, 0);
        check("idle_after_ack", {busy, req_ready}, 2'b01);

        for (int i = 0; i < 8; i++) begin
            run_op(3'(i), 32'hFFFF_FFFB, 32'h3, d, lat, s_any, u_any, f_bad);
            check($sformatf("dir_op%0d", i), d, dir_exp[i]);
            check($sformatf("dir_lat%0d", i), lat, 34);
            check($sformatf("dir_alu_ctl%0d", i), {s_any, u_any}, (i >= 4) ? 2'b11 : 2'b00);
        end

        run_op(3'd4, 6, 0, d, lat, s_any, u_any, f_bad);
        check("div_by_zero", d, 32'hFFFF_FFFF);
        check("div_by_zero_lat", lat, 0);
        run_op(3'd6, 6, 0, d, lat, s_any, u_any, f_bad);
        check("rem_by_zero", d, 32'h6);
        check("rem_by_zero_lat", lat, 0);
        run_op(3'd5, 32'h1234, 0, d, lat, s_any, u_any, f_bad);
        check("divu_by_zero", d, 32'hFFFF_FFFF);
        run_op(3'd7, 32'h1234, 0, d, lat, s_any, u_any, f_bad);
        check("remu_by_zero", d, 32'h1234);
        run_op(3'd4, 32'h8000_0000, 32'hFFFF_FFFF, d, lat, s_any, u_any, f_bad);
        check("div_overflow", d, 32'h8000_0000);
        run_op(3'd6, 32'h8000_0000, 32'hFFFF_FFFF, d, lat, s_any, u_any, f_bad);
        check("rem_overflow", d, 32'h0);

        res_ready = 0;
        @(negedge clk);
        req_valid = 1; req_op = 3'd0; req_a = 7; req_b = 9;
        @(posedge clk); #1;
        req_valid = 0;
        lat = 0;
        while (!res_valid && lat < 100) begin @(posedge clk); #1; lat++; end
        d0 = res_data;
        check("bp_result", d0, 32'd63);
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            check("bp_hold", {res_valid, req_ready, res_data}, {2'b10, d0});
        end
        @(negedge clk) res_ready = 1;
        @(posedge clk); #1;
        check("bp_release", {res_valid, busy, req_ready}, 3'b001);

        @(negedge clk);
        req_valid = 1; req_op = 3'd0; req_a = 5; req_b = 6;
        @(posedge clk); #1;
        req_valid = 0;
        repeat (11) @(posedge clk);
        @(negedge clk) flush = 1;
        @(posedge clk); #1;
        check("flush_idle", {busy, res_valid}, 2'b00);
        @(negedge clk) flush = 0;
        seen = 0;
        repeat (40) begin @(posedge clk); #1; seen |= res_valid; end
        check("flush_no_result", seen, 0);
        run_op(3'd0, 5, 6, d, lat, s_any, u_any, f_bad);
        check("mul_after_flush", d, 32'h1E);

        @(negedge clk);
        req_valid = 1; req_op = 3'd4; req_a = 1000; req_b = 7;
        @(posedge clk); #1;
        req_valid = 0;
        repeat (15) @(posedge clk);
        #2 rst_n = 0;
        #1;
        check("areset_busy", {busy, res_valid}, 2'b00);
        check("areset_alu", {alu_op1, alu_op2, alu_sub, alu_unsigned}, 0);
        check("areset_data", res_data, 0);
        @(negedge clk) rst_n = 1;

        for (int i = 0; i < 40; i++) begin
            logic [2:0]  op;
            logic [31:0] a, b;
            op = 3'($urandom_range(0, 7));
            a  = pick();
            b  = pick();
            run_op(op, a, b, d, lat, s_any, u_any, f_bad);
            check($sformatf("rand%0d_op%0d_%h_%h", i, op, a, b), d, model(op, a, b));
            check($sformatf("rand%0d_lat", i), lat, (op[2] && b == 0) ? 0 : 34);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
